// File: rtl/conv_row_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// conv_row_sequencer
//
// Purpose:
//   Sequences one convolution PE's multiply/accumulate over a single ifmap
//   row. A resident FILTER_TAPS-tap filter (8 bits per tap) is applied to a
//   binary spike row of IFMAP_LENGTH bits. One tap is processed per clock.
//   Each finished window produces a PSUM_WIDTH-bit partial sum, which is sent
//   as a 64-bit NoC packet. Packet destinations rotate over NUM_ADDERS adder
//   nodes. After the last window, an optional ifmap-forward packet carries
//   the row to a neighbouring PE.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous, active-high reset
//   i_filter_valid  filter word offered
//   o_filter_ready  filter word accepted on valid&ready (IDLE only)
//   i_filter_data   tap k = i_filter_data[8k+:8]
//   i_ifmap_valid   ifmap row offered
//   o_ifmap_ready   row accepted on valid&ready
//                   (IDLE, filter loaded, no filter offered)
//   i_ifmap_data    bit i = spike at column i
//   i_fwd_en        sampled at row accept: emit forward packet after the row
//   i_fwd_dest      sampled at row accept: forward packet destination
//   o_pkt_valid     packet offered to the router
//   i_pkt_ready     router accepts on valid&ready
//   o_pkt_data      {dest[63:60], src[59:56], type[55:54], zero, payload}
//   o_busy          high whenever the sequencer is not idle
//   o_row_done      one-cycle pulse as the row finishes
// ---------------------------------------------------------------------------
module conv_row_sequencer #(
  parameter logic [3:0] PE_ADDRESS   = 4'b0000,
  parameter int         IFMAP_LENGTH = 25,
  parameter int         FILTER_TAPS  = 5,
  parameter int         NUM_WINDOWS  = IFMAP_LENGTH - FILTER_TAPS + 1,
  parameter int         PSUM_WIDTH   = 13,
  parameter int         NUM_ADDERS   = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_filter_valid,
  output logic                     o_filter_ready,
  input  logic [FILTER_TAPS*8-1:0] i_filter_data,
  input  logic                     i_ifmap_valid,
  output logic                     o_ifmap_ready,
  input  logic [IFMAP_LENGTH-1:0]  i_ifmap_data,
  input  logic                     i_fwd_en,
  input  logic [3:0]               i_fwd_dest,
  output logic                     o_pkt_valid,
  input  logic                     i_pkt_ready,
  output logic [63:0]              o_pkt_data,
  output logic                     o_busy,
  output logic                     o_row_done
);

  localparam int WIN_W    = $clog2(NUM_WINDOWS);
  localparam int TAP_W    = $clog2(FILTER_TAPS);
  localparam int COL_W    = $clog2(IFMAP_LENGTH);
  localparam int IDX_W    = $clog2(NUM_ADDERS);
  localparam int PAD_PSUM = 54 - PSUM_WIDTH;
  localparam int PAD_FWD  = 54 - IFMAP_LENGTH;

  localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(NUM_WINDOWS - 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FILTER_TAPS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ADDERS - 1);

  localparam logic [1:0] TYPE_PSUM = 2'b10;
  localparam logic [1:0] TYPE_FWD  = 2'b00;

  // Destination rotation over the adder nodes, index 0 first.
  localparam logic [3:0] ADDER_DEST [NUM_ADDERS] = '{
    4'b0010, 4'b0110, 4'b1011, 4'b1111, 4'b1110, 4'b1001, 4'b1101
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_FWD,
    S_FWD_WAIT,
    S_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                    r_state;
  logic [FILTER_TAPS*8-1:0]  r_filter;
  logic                      r_filter_loaded;
  logic [IFMAP_LENGTH-1:0]   r_ifmap;
  logic                      r_fwd_en;
  logic [3:0]                r_fwd_dest;
  logic [PSUM_WIDTH-1:0]     r_acc;
  logic [WIN_W-1:0]          r_win;
  logic [TAP_W-1:0]          r_tap;
  logic [IDX_W-1:0]          r_adder_idx;
  logic [PSUM_WIDTH-1:0]     r_psum;
  logic                      r_psum_pend;
  logic                      r_fwd_pend;
  logic                      r_idle;      // registered copy of "state is IDLE"
  logic                      r_busy;
  logic                      r_row_done;

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  logic [7:0]            w_taps [FILTER_TAPS];
  logic [7:0]            w_tap_val;
  logic [COL_W-1:0]      w_col;
  logic                  w_spike;
  logic [PSUM_WIDTH-1:0] w_prod;
  logic [PSUM_WIDTH-1:0] w_sum;
  logic                  w_ifmap_ready;
  logic                  w_psum_hs;
  logic                  w_fwd_hs;
  logic [63:0]           w_psum_pkt;
  logic [63:0]           w_fwd_pkt;

  // Unpack the filter word into per-tap bytes.
  generate
    for (genvar gi = 0; gi < FILTER_TAPS; gi++) begin : g_tap
      assign w_taps[gi] = r_filter[8*gi +: 8];
    end
  endgenerate

  // The current column is window start plus tap offset. A spike gates
  // the tap weight; there is no true multiplier.
  assign w_col     = COL_W'(r_win) + COL_W'(r_tap);
  assign w_spike   = r_ifmap[w_col];
  assign w_tap_val = w_taps[r_tap];
  assign w_prod    = w_spike ? PSUM_WIDTH'(w_tap_val) : '0;
  assign w_sum     = r_acc + w_prod;

  // A row is only taken when no filter is offered, so the filter wins ties.
  assign w_ifmap_ready = r_idle & r_filter_loaded & ~i_filter_valid;

  assign w_psum_hs = r_psum_pend & i_pkt_ready;
  assign w_fwd_hs  = r_fwd_pend & i_pkt_ready;

  // Packets are built purely from registers. They therefore stay stable
  // while the router back-pressures.
  assign w_psum_pkt = {ADDER_DEST[r_adder_idx], PE_ADDRESS, TYPE_PSUM,
                       {PAD_PSUM{1'b0}}, r_psum};
  assign w_fwd_pkt  = {r_fwd_dest, PE_ADDRESS, TYPE_FWD,
                       {PAD_FWD{1'b0}}, r_ifmap};

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_filter        <= '0;
      r_filter_loaded <= 1'b0;
      r_ifmap         <= '0;
      r_fwd_en        <= 1'b0;
      r_fwd_dest      <= '0;
      r_acc           <= '0;
      r_win           <= '0;
      r_tap           <= '0;
      r_adder_idx     <= '0;
      r_psum          <= '0;
      r_psum_pend     <= 1'b0;
      r_fwd_pend      <= 1'b0;
      r_idle          <= 1'b0;
      r_busy          <= 1'b0;
      r_row_done      <= 1'b0;
    end else begin
      r_row_done <= 1'b0;

      // Psum handshake: free the slot and advance the adder rotation.
      // The rotation is never cleared between rows.
      if (w_psum_hs) begin
        r_psum_pend <= 1'b0;
        if (r_adder_idx == LAST_IDX) begin
          r_adder_idx <= '0;
        end else begin
          r_adder_idx <= r_adder_idx + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_idle <= 1'b1;
          if (i_filter_valid && r_idle) begin
            r_filter        <= i_filter_data;
            r_filter_loaded <= 1'b1;
          end else if (i_ifmap_valid && w_ifmap_ready) begin
            r_ifmap    <= i_ifmap_data;
            r_fwd_en   <= i_fwd_en;
            r_fwd_dest <= i_fwd_dest;
            r_win      <= '0;
            r_tap      <= '0;
            r_acc      <= '0;
            r_idle     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MAC;
          end
        end

        S_MAC: begin
          if (r_tap != LAST_TAP) begin
            r_acc <= w_sum;
            r_tap <= r_tap + 1'b1;
          end else if (!r_psum_pend) begin
            // The last tap folds straight into the psum register. If the
            // slot is still occupied, this branch is skipped and every MAC
            // register holds until the router drains it.
            r_psum      <= w_sum;
            r_psum_pend <= 1'b1;
            r_acc       <= '0;
            r_tap       <= '0;
            if (r_win == LAST_WIN) begin
              r_state <= S_FWD;
            end else begin
              r_win <= r_win + 1'b1;
            end
          end
        end

        S_FWD: begin
          // The forward packet must not overlap the final psum on the port.
          if (!r_psum_pend) begin
            if (r_fwd_en) begin
              r_fwd_pend <= 1'b1;
              r_state    <= S_FWD_WAIT;
            end else begin
              r_row_done <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end

        S_FWD_WAIT: begin
          if (w_fwd_hs) begin
            r_fwd_pend <= 1'b0;
            r_row_done <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_filter_ready = r_idle;
  assign o_ifmap_ready  = w_ifmap_ready;
  assign o_pkt_valid    = r_psum_pend | r_fwd_pend;
  assign o_pkt_data     = r_psum_pend ? w_psum_pkt :
                          r_fwd_pend  ? w_fwd_pkt  : 64'd0;
  assign o_busy         = r_busy;
  assign o_row_done     = r_row_done;

endmodule

// File: tb/tb_conv_row_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_conv_row_sequencer
//
// Purpose:
//   Directed testbench for conv_row_sequencer. A vector table of
//   filter/ifmap rows with hand-computed partial sums drives the design.
//   Hand-written sequences cover reset, back-pressure, mid-row abort and
//   the filter/ifmap tie.
// ---------------------------------------------------------------------------
module tb_conv_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_filter_valid;
  logic        o_filter_ready;
  logic [39:0] i_filter_data;
  logic        i_ifmap_valid;
  logic        o_ifmap_ready;
  logic [24:0] i_ifmap_data;
  logic        i_fwd_en;
  logic [3:0]  i_fwd_dest;
  logic        o_pkt_valid;
  logic        i_pkt_ready;
  logic [63:0] o_pkt_data;
  logic        o_busy;
  logic        o_row_done;

  always #5 clk = ~clk;

  conv_row_sequencer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_filter_valid (i_filter_valid),
    .o_filter_ready (o_filter_ready),
    .i_filter_data  (i_filter_data),
    .i_ifmap_valid  (i_ifmap_valid),
    .o_ifmap_ready  (o_ifmap_ready),
    .i_ifmap_data   (i_ifmap_data),
    .i_fwd_en       (i_fwd_en),
    .i_fwd_dest     (i_fwd_dest),
    .o_pkt_valid    (o_pkt_valid),
    .i_pkt_ready    (i_pkt_ready),
    .o_pkt_data     (o_pkt_data),
    .o_busy         (o_busy),
    .o_row_done     (o_row_done)
  );

  // One row of stimulus plus its hand-computed psums.
  // Windows 0-4 are listed individually. Windows 5-19 share 'mid'.
  // Window 20 is 'last'.
  typedef struct {
    logic [39:0]      filter;
    logic [24:0]      ifmap;
    logic             fwd_en;
    logic [3:0]       fwd_dest;
    logic [4:0][12:0] first5;
    logic [12:0]      mid;
    logic [12:0]      last;
  } vec_t;

  vec_t        vecs [7];
  logic [3:0]  adder_t [7];
  logic [63:0] pq [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_idx = 0;

  // Capture every accepted packet, in order.
  always @(negedge clk) begin
    if (!rst && o_pkt_valid && i_pkt_ready) pq.push_back(o_pkt_data);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [39:0] f, input logic [24:0] m,
                              input logic fe, input logic [3:0] fd,
                              input int p0, input int p1, input int p2,
                              input int p3, input int p4,
                              input int pm, input int pl);
    vec_t v;
    v.filter    = f;
    v.ifmap     = m;
    v.fwd_en    = fe;
    v.fwd_dest  = fd;
    v.first5[0] = 13'(p0);
    v.first5[1] = 13'(p1);
    v.first5[2] = 13'(p2);
    v.first5[3] = 13'(p3);
    v.first5[4] = 13'(p4);
    v.mid       = 13'(pm);
    v.last      = 13'(pl);
    return v;
  endfunction

  function automatic logic [12:0] exp_psum(input vec_t v, input int w);
    if (w < 5)  return v.first5[w];
    if (w < 20) return v.mid;
    return v.last;
  endfunction

  task automatic load_filter(input logic [39:0] data);
    bit ok = 0;
    @(posedge clk); #1;
    i_filter_valid = 1'b1;
    i_filter_data  = data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_filter_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    i_filter_valid = 1'b0;
    check("filter_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_row(input vec_t v);
    bit ok = 0;
    @(posedge clk); #1;
    i_ifmap_valid = 1'b1;
    i_ifmap_data  = v.ifmap;
    i_fwd_en      = v.fwd_en;
    i_fwd_dest    = v.fwd_dest;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ifmap_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    i_ifmap_valid = 1'b0;
    check("ifmap_accept", 64'(ok), 64'd1);
  endtask

  // Entered one time unit after the accept edge.
  // Counts edges to the first and 21st pkt_valid rise and to row_done.
  task automatic wait_row(input bit chk_timing);
    int   rises = 0, first_n = 0, last_n = 0, done_cnt = 0, after = -1;
    logic prev = 1'b0;
    bit   busy_seen = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      if (o_pkt_valid && !prev) begin
        rises++;
        if (rises == 1)  first_n = n;
        if (rises == 21) last_n  = n;
      end
      prev = o_pkt_valid;
      if (o_busy) busy_seen = 1;
      if (o_row_done) done_cnt++;
      if (done_cnt > 0) begin
        after++;
        if (after == 3) break;
      end
    end
    check("row_done_pulses", 64'(done_cnt), 64'd1);
    check("busy_during_row", 64'(busy_seen), 64'd1);
    check("busy_after_row", 64'(o_busy), 64'd0);
    if (chk_timing) begin
      check("first_psum_latency", 64'(first_n), 64'd5);
      check("last_psum_edge", 64'(last_n), 64'd105);
    end
  endtask

  task automatic check_row(input vec_t v, input int id);
    int          n_exp = 21 + (v.fwd_en ? 1 : 0);
    logic [63:0] got, exp;
    check("pkt_count", 64'(pq.size()), 64'(n_exp));
    for (int w = 0; w < 21; w++) begin
      if (pq.size() == 0) break;
      got = pq.pop_front();
      exp = {adder_t[exp_idx], 4'h0, 2'b10, 41'd0, exp_psum(v, w)};
      check($sformatf("row%0d psum w%0d", id, w), got, exp);
      exp_idx = (exp_idx + 1) % 7;
    end
    if (v.fwd_en && pq.size() > 0) begin
      got = pq.pop_front();
      exp = {v.fwd_dest, 4'h0, 2'b00, 29'd0, v.ifmap};
      check($sformatf("row%0d fwd", id), got, exp);
    end
    pq.delete();
    $display("row %0d: filter=%h ifmap=%h fwd_en=%0d checked", id, v.filter, v.ifmap, v.fwd_en);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [63:0] held;
    bit          ok;
    int          bad_hold;

    rst = 1'b1;
    i_filter_valid = 0; i_filter_data = '0;
    i_ifmap_valid = 0;  i_ifmap_data = '0;
    i_fwd_en = 0; i_fwd_dest = '0; i_pkt_ready = 1'b1;

    adder_t = '{4'b0010, 4'b0110, 4'b1011, 4'b1111, 4'b1110, 4'b1001, 4'b1101};

    //             filter          ifmap       fe  dest  w0  w1  w2  w3  w4  mid  last
    vecs[0] = mk(40'h0101010101, 25'h1FFFFFF, 1, 4'h3,   5,  5,  5,  5,  5,   5,    5);
    vecs[1] = mk(40'h0504030201, 25'h0000001, 0, 4'h0,   1,  0,  0,  0,  0,   0,    0);
    vecs[2] = mk(40'h0504030201, 25'h0000010, 1, 4'hA,   5,  4,  3,  2,  1,   0,    0);
    vecs[3] = mk(40'hFFFFFFFFFF, 25'h1FFFFFF, 1, 4'h5, 1275,1275,1275,1275,1275,1275,1275);
    vecs[4] = mk(40'h0504030201, 25'h1000000, 1, 4'hC,   0,  0,  0,  0,  0,   0,    5);
    vecs[5] = mk(40'h32281E140A, 25'h0000011, 0, 4'h0,  60, 40, 30, 20, 10,   0,    0);
    vecs[6] = mk(40'h0504030201, 25'h0000000, 1, 4'hF,   0,  0,  0,  0,  0,   0,    0);

    // Reset: everything low, even with a filter offered.
    i_filter_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl_outputs", {59'd0, o_pkt_valid, o_busy, o_row_done, o_filter_ready, o_ifmap_ready}, 64'd0);
    check("reset_pkt_data", o_pkt_data, 64'd0);
    @(posedge clk); #1;
    i_filter_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_filter_ready", 64'(o_filter_ready), 64'd1);
    check("no_filter_ifmap_ready", 64'(o_ifmap_ready), 64'd0);

    // Table-driven rows at full router throughput.
    for (int i = 0; i < 7; i++) begin
      load_filter(vecs[i].filter);
      send_row(vecs[i]);
      wait_row(1'b1);
      check_row(vecs[i], i);
    end

    // Back-pressure: the first psum is held for 40 cycles. The row must
    // then finish with the same values and rotation.
    load_filter(vecs[0].filter);
    i_pkt_ready = 1'b0;
    send_row(vecs[0]);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_pkt_valid) begin ok = 1; break; end
    end
    check("bp_first_valid", 64'(ok), 64'd1);
    held = o_pkt_data;
    check("bp_first_pkt", held, {adder_t[exp_idx], 4'h0, 2'b10, 41'd0, 13'd5});
    bad_hold = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!o_pkt_valid || o_pkt_data !== held || !o_busy) bad_hold++;
    end
    check("bp_hold_cycles_bad", 64'(bad_hold), 64'd0);
    i_pkt_ready = 1'b1;
    wait_row(1'b0);
    check_row(vecs[0], 7);

    // The next row continues the adder rotation: 21 psums wrap back to 0010.
    send_row(vecs[0]);
    wait_row(1'b1);
    check("rotation_continue", (pq.size() > 0) ? {60'd0, pq[0][63:60]} : 64'hX, 64'h2);
    check_row(vecs[0], 8);

    // Abort a row with reset just after its third psum handshake.
    send_row(vecs[0]);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pq.size() >= 3) begin ok = 1; break; end
    end
    check("abort_three_psums", 64'(ok), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", {59'd0, o_pkt_valid, o_busy, o_row_done, o_filter_ready, o_ifmap_ready}, 64'd0);
    check("async_reset_pkt_data", o_pkt_data, 64'd0);
    pq.delete();
    exp_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_abort_filter_ready", 64'(o_filter_ready), 64'd1);
    check("post_abort_ifmap_ready", 64'(o_ifmap_ready), 64'd0);

    // Filter and ifmap offered together: the filter goes first, the row
    // one cycle later, and the row uses the new filter.
    load_filter(40'h0101010101);
    v = vecs[2];
    v.fwd_dest = 4'h7;
    @(posedge clk); #1;
    i_filter_valid = 1'b1; i_filter_data = v.filter;
    i_ifmap_valid  = 1'b1; i_ifmap_data  = v.ifmap;
    i_fwd_en = v.fwd_en;   i_fwd_dest    = v.fwd_dest;
    @(negedge clk);
    check("tie_filter_ready", 64'(o_filter_ready), 64'd1);
    check("tie_ifmap_blocked", 64'(o_ifmap_ready), 64'd0);
    @(posedge clk); #1;
    i_filter_valid = 1'b0;
    @(negedge clk);
    check("tie_ifmap_next", 64'(o_ifmap_ready), 64'd1);
    @(posedge clk); #1;
    i_ifmap_valid = 1'b0;
    wait_row(1'b1);
    check_row(v, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
